// File: rtl/can_pkg.sv
// can_pkg: shared state type, frame constants and CRC helper for the
// CAN transmitter. CAN_ACK_CHECK_EN (optional) is consumed by can_xmit.
package can_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SOF,
        ARB,
        CTRL,
        DATA,
        CRC,
        CRCDEL,
        ACK,
        ACKDEL,
        EOF,
        IFS
    } canStateT;

    localparam logic [14:0] CRC_POLY  = 15'h4599;
    localparam logic [1:0]  FT_DATA   = 2'b00;
    localparam logic [1:0]  FT_REMOTE = 2'b01;
    localparam int          EOF_BITS  = 7;
    localparam int          STUFF_RUN = 5;

    // One serial CRC15 step: shift in bit b, MSB-first.
    function automatic logic [14:0] crc15_step(
        input logic [14:0] crc,
        input logic        b
    );
        logic [14:0] nxt;
        nxt = {crc[13:0], 1'b0};
        if (b ^ crc[14]) begin
            nxt = nxt ^ CRC_POLY;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/can_bit_timer.sv
// can_bit_timer: quantum divider and bit segment counter. bit_start marks
// the last PCLK of a bit; sample marks the last PCLK of phase segment 1.
module can_bit_timer
    import can_pkg::*;
#(
    parameter int SEG2_QUANTA = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] quanta_div,
    input  logic [5:0] prop_quanta,
    input  logic [5:0] seg1_quanta,
    output logic       bit_start,
    output logic       sample
);

    localparam logic [7:0] SEG2_Q = 8'(SEG2_QUANTA);

    logic [7:0] qcnt_q, qcnt_d;
    logic [7:0] tq_q, tq_d;
    logic [7:0] last_tq;
    logic [7:0] samp_tq;
    logic       q_end;

    // Quantum index 0 is sync; the bit ends after prop+seg1+seg2 more.
    always_comb begin
        samp_tq   = 8'(prop_quanta) + 8'(seg1_quanta);
        last_tq   = samp_tq + SEG2_Q;
        q_end     = (qcnt_q == quanta_div);
        bit_start = !rst && q_end && (tq_q == last_tq);
        sample    = !rst && q_end && (tq_q == samp_tq);
        qcnt_d    = q_end ? 8'd0 : qcnt_q + 8'd1;
        tq_d      = tq_q;
        if (q_end) begin
            tq_d = (tq_q == last_tq) ? 8'd0 : tq_q + 8'd1;
        end
    end

    // Counters restart from the sync quantum whenever held in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            qcnt_q <= 8'd0;
            tq_q   <= 8'd0;
        end else begin
            qcnt_q <= qcnt_d;
            tq_q   <= tq_d;
        end
    end

endmodule

// File: rtl/can_xmit.sv
// can_xmit: CAN 2.0 frame builder, bit stuffer and serialiser.
// Define CAN_ACK_CHECK_EN to flag a missing dominant ACK on ack_err.
module can_xmit
    import can_pkg::*;
#(
    parameter int SEG2_QUANTA = 2,
    parameter int IFS_BITS    = 3
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        startXmit,
    input  logic [7:0]  quantaDiv,
    input  logic [5:0]  propQuanta,
    input  logic [5:0]  seg1Quanta,
    input  logic [3:0]  datalen,
    input  logic        format,
    input  logic [1:0]  frameType,
    input  logic [28:0] id,
    input  logic [63:0] xmitdata,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic        ack_err
);

    canStateT    state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        ack_err_q, ack_err_d;
    logic [14:0] crc_q, crc_d;
    logic [2:0]  run_q, run_d;

    logic [7:0]  div_q, div_d;
    logic [5:0]  prop_q, prop_d;
    logic [5:0]  seg1_q, seg1_d;
    logic [3:0]  dlc_q, dlc_d;
    logic        ext_q, ext_d;
    logic        rtr_q, rtr_d;
    logic [28:0] id_q, id_d;
    logic [63:0] data_q, data_d;

    logic        bit_start;
    logic        sample_pt;
    logic        timer_rst;

    logic [31:0] arb_vec;
    logic [5:0]  ctrl_vec;
    logic [6:0]  data_bits;
    logic [6:0]  field_last;
    canStateT    nxt_state;
    logic [6:0]  nxt_cnt;
    logic        nxt_bit;
    logic        in_stuff;

    assign timer_rst = PRESET || (state_q == IDLE);

    can_bit_timer #(
        .SEG2_QUANTA(SEG2_QUANTA)
    ) u_timer (
        .clk        (PCLK),
        .rst        (timer_rst),
        .quanta_div (div_q),
        .prop_quanta(prop_q),
        .seg1_quanta(seg1_q),
        .bit_start  (bit_start),
        .sample     (sample_pt)
    );

    // Frame geometry: the field position and value of the next bit.
    always_comb begin
        if (ext_q) begin
            arb_vec = {id_q[28:18], 1'b1, 1'b1, id_q[17:0], rtr_q};
        end else begin
            arb_vec = {id_q[28:18], rtr_q, 20'd0};
        end
        ctrl_vec = {2'b00, dlc_q};
        if (rtr_q) begin
            data_bits = 7'd0;
        end else if (dlc_q > 4'd8) begin
            data_bits = 7'd64;
        end else begin
            data_bits = {dlc_q, 3'b000};
        end

        unique case (state_q)
            ARB:     field_last = ext_q ? 7'd31 : 7'd11;
            CTRL:    field_last = 7'd5;
            DATA:    field_last = data_bits - 7'd1;
            CRC:     field_last = 7'd14;
            EOF:     field_last = 7'(EOF_BITS - 1);
            IFS:     field_last = 7'(IFS_BITS - 1);
            default: field_last = 7'd0;
        endcase

        nxt_state = state_q;
        nxt_cnt   = cnt_q + 7'd1;
        if (cnt_q == field_last) begin
            nxt_cnt = 7'd0;
            unique case (state_q)
                SOF:     nxt_state = ARB;
                ARB:     nxt_state = CTRL;
                CTRL:    nxt_state = (data_bits != 7'd0) ? DATA : CRC;
                DATA:    nxt_state = CRC;
                CRC:     nxt_state = CRCDEL;
                CRCDEL:  nxt_state = ACK;
                ACK:     nxt_state = ACKDEL;
                ACKDEL:  nxt_state = EOF;
                EOF:     nxt_state = (IFS_BITS > 0) ? IFS : IDLE;
                default: nxt_state = IDLE;
            endcase
        end

        unique case (nxt_state)
            SOF:     nxt_bit = 1'b0;
            ARB:     nxt_bit = arb_vec[5'd31 - nxt_cnt[4:0]];
            CTRL:    nxt_bit = ctrl_vec[3'd5 - nxt_cnt[2:0]];
            DATA:    nxt_bit = data_q[6'd63 - nxt_cnt[5:0]];
            CRC:     nxt_bit = crc_q[4'd14 - nxt_cnt[3:0]];
            default: nxt_bit = 1'b1;
        endcase

        in_stuff = state_q inside {SOF, ARB, CTRL, DATA, CRC};
    end

    // Next state: accept, stuff-or-advance on each bit boundary, ACK check.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        ack_err_d = ack_err_q;
        crc_d     = crc_q;
        run_d     = run_q;
        div_d     = div_q;
        prop_d    = prop_q;
        seg1_d    = seg1_q;
        dlc_d     = dlc_q;
        ext_d     = ext_q;
        rtr_d     = rtr_q;
        id_d      = id_q;
        data_d    = data_q;

        if (state_q == IDLE) begin
            if (startXmit && !frameType[1]) begin
                div_d     = quantaDiv;
                prop_d    = propQuanta;
                seg1_d    = seg1Quanta;
                dlc_d     = datalen;
                ext_d     = format;
                rtr_d     = (frameType == FT_REMOTE);
                id_d      = id;
                data_d    = xmitdata;
                state_d   = SOF;
                cnt_d     = 7'd0;
                tx_d      = 1'b0;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                crc_d     = 15'd0;
                run_d     = 3'd1;
            end
        end else if (bit_start) begin
            if (in_stuff && run_q == 3'(STUFF_RUN)) begin
                tx_d  = ~tx_q;
                run_d = 3'd1;
            end else begin
                state_d = nxt_state;
                cnt_d   = nxt_cnt;
                tx_d    = nxt_bit;
                if (nxt_bit != tx_q) begin
                    run_d = 3'd1;
                end else if (run_q != 3'd7) begin
                    run_d = run_q + 3'd1;
                end
                if (nxt_state inside {ARB, CTRL, DATA}) begin
                    crc_d = crc15_step(crc_q, nxt_bit);
                end
                if (nxt_state == IDLE) begin
                    busy_d = 1'b0;
                end
            end
        end

`ifdef CAN_ACK_CHECK_EN
        if (state_q == ACK && sample_pt && rx) begin
            ack_err_d = 1'b1;
        end
`else
        ack_err_d = 1'b0;
`endif
    end

`ifndef CAN_ACK_CHECK_EN
    logic unused_ack;
    assign unused_ack = rx ^ sample_pt;
`endif

    // State, serialiser and shadow configuration registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= 7'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b0;
            crc_q     <= 15'd0;
            run_q     <= 3'd0;
            div_q     <= 8'd0;
            prop_q    <= 6'd0;
            seg1_q    <= 6'd0;
            dlc_q     <= 4'd0;
            ext_q     <= 1'b0;
            rtr_q     <= 1'b0;
            id_q      <= 29'd0;
            data_q    <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ack_err_q <= ack_err_d;
            crc_q     <= crc_d;
            run_q     <= run_d;
            div_q     <= div_d;
            prop_q    <= prop_d;
            seg1_q    <= seg1_d;
            dlc_q     <= dlc_d;
            ext_q     <= ext_d;
            rtr_q     <= rtr_d;
            id_q      <= id_d;
            data_q    <= data_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_can_xmit.sv
// tb_can_xmit: table-driven frame vectors plus reset, illegal-type and
// ACK sequences for can_xmit (SEG2_QUANTA=2, IFS_BITS=3).
module tb_can_xmit;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        startXmit;
    logic [7:0]  quantaDiv;
    logic [5:0]  propQuanta;
    logic [5:0]  seg1Quanta;
    logic [3:0]  datalen;
    logic        format;
    logic [1:0]  frameType;
    logic [28:0] id;
    logic [63:0] xmitdata;
    logic        rx;
    logic        tx;
    logic        busy;
    logic        ack_err;

    can_xmit #(
        .SEG2_QUANTA(2),
        .IFS_BITS   (3)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .startXmit (startXmit),
        .quantaDiv (quantaDiv),
        .propQuanta(propQuanta),
        .seg1Quanta(seg1Quanta),
        .datalen   (datalen),
        .format    (format),
        .frameType (frameType),
        .id        (id),
        .xmitdata  (xmitdata),
        .rx        (rx),
        .tx        (tx),
        .busy      (busy),
        .ack_err   (ack_err)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0]  div;
        logic [5:0]  prop;
        logic [5:0]  seg1;
        logic        fmt;
        logic [1:0]  ft;
        logic [28:0] fid;
        logic [3:0]  dlc;
        logic [63:0] data;
        int          ulen;
        int          nstuff;
        logic [6:0]  head;
        bit          ack_low;
        int          start_at;
    } vec_t;

    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;
    bit   mdl_u[$];
    bit   mdl_s[$];
    bit   cap[$];
    bit   du[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        quantaDiv  = v.div;
        propQuanta = v.prop;
        seg1Quanta = v.seg1;
        format     = v.fmt;
        frameType  = v.ft;
        id         = v.fid;
        datalen    = v.dlc;
        xmitdata   = v.data;
    endtask

    // Golden frame: unstuffed SOF..CRC, then stuffed copy.
    task automatic build_model(input vec_t v);
        logic [14:0] c;
        int          nb;
        int          run;
        bit          last;
        mdl_u.delete();
        mdl_s.delete();
        mdl_u.push_back(1'b0);
        for (int i = 0; i < 11; i++) mdl_u.push_back(v.fid[28-i]);
        if (v.fmt) begin
            mdl_u.push_back(1'b1);
            mdl_u.push_back(1'b1);
            for (int i = 0; i < 18; i++) mdl_u.push_back(v.fid[17-i]);
        end
        mdl_u.push_back(v.ft[0]);
        mdl_u.push_back(1'b0);
        mdl_u.push_back(1'b0);
        for (int i = 0; i < 4; i++) mdl_u.push_back(v.dlc[3-i]);
        nb = v.ft[0] ? 0 : ((v.dlc > 8) ? 8 : int'(v.dlc));
        for (int i = 0; i < nb * 8; i++) mdl_u.push_back(v.data[63-i]);
        c = 15'd0;
        foreach (mdl_u[i]) begin
            if (mdl_u[i] ^ c[14]) c = {c[13:0], 1'b0} ^ 15'h4599;
            else c = {c[13:0], 1'b0};
        end
        for (int i = 0; i < 15; i++) mdl_u.push_back(c[14-i]);
        run  = 0;
        last = 1'b0;
        foreach (mdl_u[i]) begin
            mdl_s.push_back(mdl_u[i]);
            if (run > 0 && mdl_u[i] == last) run++;
            else begin
                run  = 1;
                last = mdl_u[i];
            end
            if (run == 5) begin
                mdl_s.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
    endtask

    task automatic run_vec(input int vi);
        vec_t  v;
        int    n;
        int    total;
        int    ack_bit;
        int    early;
        int    unstable;
        int    mm;
        int    run;
        int    bad;
        int    idx;
        int    p;
        bit    cur;
        bit    last;
        bit    exp_b;
        logic [6:0] hd;
        logic [3:0] dg;
        logic  exp_ae;
        v = vecs[vi];
        build_model(v);
        n       = (1 + int'(v.prop) + int'(v.seg1) + 2) * (int'(v.div) + 1);
        total   = mdl_s.size() + 13;
        ack_bit = mdl_s.size() + 1;
        drive(v);
        rx        = 1'b1;
        startXmit = 1'b1;
        @(posedge PCLK);
        #1;
        startXmit = 1'b0;
        chk($sformatf("v%0d_ack_clr", vi), ack_err, 0);
        chk($sformatf("v%0d_sof_tx", vi), tx, 0);
        chk($sformatf("v%0d_sof_busy", vi), busy, 1);
        cap.delete();
        early    = 0;
        unstable = 0;
        cur      = 1'b0;
        for (int k = 0; k < total * n; k++) begin
            if (k > 0) begin
                @(posedge PCLK);
                #1;
            end
            if (busy !== 1'b1) early++;
            if (k % n == 0) begin
                cur = tx;
                cap.push_back(tx);
            end else if (tx !== cur) begin
                unstable++;
            end
            rx = (v.ack_low && (k / n) == ack_bit) ? 1'b0 : 1'b1;
            if (k == v.start_at) begin
                startXmit = 1'b1;
                id        = ~v.fid;
                datalen   = 4'd0;
                format    = ~v.fmt;
            end else if (k == v.start_at + 1) begin
                startXmit = 1'b0;
            end
        end
        @(posedge PCLK);
        #1;
        rx = 1'b1;
        chk($sformatf("v%0d_busy_held", vi), early, 0);
        chk($sformatf("v%0d_tx_stable", vi), unstable, 0);
        chk($sformatf("v%0d_busy_drop", vi), busy, 0);
        chk($sformatf("v%0d_idle_tx", vi), tx, 1);
`ifdef CAN_ACK_CHECK_EN
        exp_ae = v.ack_low ? 1'b0 : 1'b1;
`else
        exp_ae = 1'b0;
`endif
        chk($sformatf("v%0d_ack_err", vi), ack_err, exp_ae);
        for (int i = 0; i < 7; i++) hd[6-i] = cap[i];
        chk($sformatf("v%0d_head", vi), hd, v.head);
        mm = 0;
        foreach (cap[i]) begin
            exp_b = (i < mdl_s.size()) ? mdl_s[i] : 1'b1;
            if (cap[i] != exp_b) mm++;
        end
        chk($sformatf("v%0d_stream", vi), mm, 0);
        du.delete();
        run  = 0;
        last = 1'b0;
        bad  = 0;
        idx  = 0;
        while (idx < cap.size() && du.size() < v.ulen) begin
            du.push_back(cap[idx]);
            if (run > 0 && cap[idx] == last) run++;
            else begin
                run  = 1;
                last = cap[idx];
            end
            idx++;
            if (run == 5 && idx < cap.size()) begin
                if (cap[idx] == last) bad++;
                last = cap[idx];
                run  = 1;
                idx++;
            end
        end
        chk($sformatf("v%0d_stuff_ok", vi), bad, 0);
        chk($sformatf("v%0d_ulen", vi), du.size(), v.ulen);
        chk($sformatf("v%0d_slen", vi), idx, mdl_s.size());
        if (v.nstuff >= 0) begin
            chk($sformatf("v%0d_nstuff", vi), idx - int'(du.size()),
                v.nstuff);
        end
        mm = 0;
        foreach (du[i]) begin
            if (i >= mdl_u.size() || du[i] != mdl_u[i]) mm++;
        end
        chk($sformatf("v%0d_destuffed", vi), mm, 0);
        p  = v.fmt ? 35 : 15;
        dg = 4'hx;
        for (int j = 0; j < 4; j++) begin
            if (p + j < du.size()) dg[3-j] = du[p+j];
        end
        chk($sformatf("v%0d_dlc_field", vi), dg, v.dlc);
        repeat (3) @(posedge PCLK);
        #1;
    endtask

    initial begin
        PRESET     = 1'b1;
        startXmit  = 1'b0;
        quantaDiv  = 8'd0;
        propQuanta = 6'd1;
        seg1Quanta = 6'd2;
        datalen    = 4'd0;
        format     = 1'b0;
        frameType  = 2'b00;
        id         = 29'd0;
        xmitdata   = 64'd0;
        rx         = 1'b1;

        vecs[0] = '{8'd0, 6'd1, 6'd2, 1'b0, 2'b00, {11'h123, 18'd0},
                    4'd1, {8'hA5, 56'd0}, 42, -1, 7'b0001001, 1'b0, -1};
        vecs[1] = '{8'd0, 6'd1, 6'd2, 1'b0, 2'b00, 29'd0,
                    4'd0, 64'd0, 34, 6, 7'b0000010, 1'b1, -1};
        vecs[2] = '{8'd0, 6'd1, 6'd2, 1'b1, 2'b01, 29'h1FFFFFFF,
                    4'd4, 64'hDEADBEEF_CAFEF00D, 54, -1, 7'b0111110,
                    1'b0, -1};
        vecs[3] = '{8'd0, 6'd1, 6'd2, 1'b0, 2'b00, {11'h555, 18'd0},
                    4'd15, 64'h01234567_89ABCDEF, 98, -1, 7'b0101010,
                    1'b1, 200};
        vecs[4] = '{8'd1, 6'd0, 6'd0, 1'b0, 2'b00, {11'h7F0, 18'd0},
                    4'd2, {16'hFF00, 48'd0}, 50, -1, 7'b0111110,
                    1'b0, -1};
        vecs[5] = '{8'd2, 6'd2, 6'd1, 1'b0, 2'b01, {11'h001, 18'd0},
                    4'd3, 64'h55, 34, -1, 7'b0000010, 1'b0, -1};

        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack_err", ack_err, 0);
        PRESET = 1'b0;
        @(posedge PCLK);
        #1;

        for (int i = 0; i < 6; i++) run_vec(i);

        drive(vecs[0]);
        frameType = 2'b10;
        startXmit = 1'b1;
        @(posedge PCLK);
        #1;
        startXmit = 1'b0;
        chk("illegal_busy", busy, 0);
        chk("illegal_tx", tx, 1);
        repeat (20) @(posedge PCLK);
        #1;
        chk("illegal_busy_late", busy, 0);

        drive(vecs[3]);
        startXmit = 1'b1;
        @(posedge PCLK);
        #1;
        startXmit = 1'b0;
        repeat (30 * 6) @(posedge PCLK);
        #1;
        chk("mid_busy", busy, 1);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ack_err", ack_err, 0);
        PRESET = 1'b0;
        repeat (8) @(posedge PCLK);
        #1;
        chk("post_rst_tx", tx, 1);
        chk("post_rst_busy", busy, 0);

        run_vec(1);
        run_vec(0);
        run_vec(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/can_xmit.md
Name: can_xmit

Overview:
- Downstream CAN 2.0 transmitter. Consumes the configuration registers and start pulse that the APB front-end drives onto the cantintf transmit-side signals.
- Builds a standard or extended data/remote frame, computes CRC15, inserts stuff bits, applies programmable bit timing and serialises onto the tx line.
- Reports busy back to the APB status register (address 16).

Parameters:
- SEG2_QUANTA, 2, phase-segment-2 length in time quanta (1..8).
- IFS_BITS, 3, recessive intermission bits after EOF before busy drops.

Ports:
- PCLK  in  1  system clock
- PRESET  in  1  synchronous active-high reset
- startXmit  in  1  single-cycle start pulse
- quantaDiv  in  8  PCLK cycles per quantum minus 1
- propQuanta  in  6  propagation segment, in quanta
- seg1Quanta  in  6  phase segment 1, in quanta
- datalen  in  4  DLC
- format  in  1  0 = standard 11-bit ID, 1 = extended 29-bit ID
- frameType  in  2  00 data, 01 remote, 1x illegal
- id  in  29  identifier; the standard ID sits in id[28:18]
- xmitdata  in  64  payload; byte 0 = [63:56]
- rx  in  1  bus sense, used for ACK
- tx  out  1  bus drive; 1 = recessive
- busy  out  1  frame in progress
- ack_err  out  1  no dominant ACK seen; sticky until next accept

Behaviour:
- Reset (PRESET at a PCLK edge, including mid-frame): tx=1, busy=0, ack_err=0, FSM=IDLE, counters and CRC cleared. Takes effect on that same edge.
- Accept rule:
  - startXmit is accepted only when IDLE and frameType[1]==0.
  - startXmit while busy, or with frameType 1x, is ignored; busy stays as is.
  - On the accept edge, latch all config inputs into shadow registers. Later input changes have no effect on the frame in progress.
  - On the same edge, busy<=1 and tx<=0 (SOF). tx and busy change in the cycle after startXmit is high.
- Bit timing:
  - Quantum = quantaDiv+1 PCLK cycles.
  - Bit = 1 (sync) + propQuanta + seg1Quanta + SEG2_QUANTA quanta.
  - tx updates only at the start of the sync segment.
  - rx is sampled at the end of seg1.
  - propQuanta==0 and seg1Quanta==0 are legal (each segment is skipped).
- Frame field order, each field MSB first:
  - Standard: SOF(0), ID[28:18], RTR, IDE(0), r0(0), DLC[3:0].
  - Extended: SOF, ID[28:18], SRR(1), IDE(1), ID[17:0], RTR, r1(0), r0(0), DLC.
  - RTR = 1 for a remote frame.
  - Data field: min(datalen,8) bytes, data frames only. The DLC field carries the raw datalen, including values 9..15.
  - Then CRC[14:0], CRC delimiter(1), ACK slot(1), ACK delimiter(1), EOF (7 recessive), IFS (IFS_BITS recessive).
  - busy falls on the sync boundary after the last IFS bit.
- CRC:
  - Polynomial 0x4599, initial value 0.
  - Computed over unstuffed bits from SOF through the last data bit.
- Bit stuffing:
  - Applies from SOF through CRC[0].
  - After 5 consecutive equal transmitted bits, insert 1 complement bit.
  - The stuff bit starts a new run of length 1.
  - No stuffing from the CRC delimiter onward.
- FSM states: IDLE, SOF, ARB, CTRL, DATA, CRC, CRCDEL, ACK, ACKDEL, EOF, IFS. Transitions occur on bit boundaries, driven by a field bit counter.

Optional Feature:
- Macro: CAN_ACK_CHECK_EN.
- Defined: in the ACK state, rx is sampled at the sample point. If rx==1, ack_err<=1. The frame always completes normally, with no retransmission.
- Undefined: rx is ignored and ack_err is held at 0.

Decomposition:
- Shared package can_pkg holds:
  - state enum canStateT
  - CRC_POLY=15'h4599
  - FT_DATA/FT_REMOTE constants
  - EOF_BITS=7
  - STUFF_RUN=5
- Sub-module can_bit_timer: quanta divider and segment counter. Outputs a one-PCLK bit_start strobe and a sample strobe. It is held in reset while IDLE.

Test Plan:
- Standard data frame: quantaDiv=0, prop=1, seg1=2, SEG2=2, id=29'h123<<18, datalen=1, xmitdata[63:56]=8'hA5 -> 6 PCLK per bit. The destuffed stream matches the golden model, including CRC. busy=1 for the whole frame; tx=1 after busy falls.
- Stuffing: standard data frame, id=0, datalen=0 -> tx bits 0,0,0,0,0,1(stuff),0,... The stuffed bit count matches the model; no stuff bits after CRC[0].
- Extended remote frame: format=1, frameType=01, id=29'h1FFFFFFF, datalen=4 -> SRR=1, IDE=1, RTR=1, DLC=4 sent, no data field.
- Oversize DLC and busy protection: datalen=15 -> DLC field 1111 and 8 data bytes sent. A startXmit pulse mid-frame is ignored, and the bus output is unchanged versus a run without it.
- Reset mid-DATA: assert PRESET -> the next edge gives tx=1, busy=0. A new startXmit afterwards yields a clean SOF.
- ACK (CAN_ACK_CHECK_EN defined): rx held 1 -> ack_err=1 after the ACK slot. rx driven 0 in the ACK slot -> ack_err=0. ack_err clears on the next accept.
